// File: rtl/ram_param.sv
// ram_param: parametrised single-port synchronous RAM with a pipelined read
// (READ_LAT 1 or 2) plus valid strobe, selectable read-during-write ordering
// and a one-word-per-cycle clear engine.
// Optional feature: define RAM_PARITY_EN to store an even-parity bit per word
// and flag mismatches on completed reads through err.
module ram_param #(
    parameter int                DATA_W     = 4,
    parameter int                ADDR_W     = 12,
    parameter int                READ_LAT   = 1,
    parameter int                RDW_MODE   = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = '0,
    parameter bit                INIT_CLEAR = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              clear,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LAST  = READ_LAT - 1;
`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              init_pend;
    logic              start_clr;
    logic              wr_en;
    logic              rd_en;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] clr_word;
    logic [WORD_W-1:0] rd_word;

    logic [READ_LAT-1:0] vld_pipe;
    logic [WORD_W-1:0]   dat_pipe [READ_LAT];

    // A clear request beats any read/write issued in the same cycle.
    assign start_clr = (state == S_IDLE) && (clear || init_pend);
    assign wr_en     = (state == S_IDLE) && !start_clr && write;
    assign rd_en     = (state == S_IDLE) && !start_clr && read;
    assign busy      = (state == S_CLEAR);

`ifdef RAM_PARITY_EN
    assign wr_word  = {^in, in};
    assign clr_word = {^CLEAR_VAL, CLEAR_VAL};
`else
    assign wr_word  = in;
    assign clr_word = CLEAR_VAL;
`endif

    // Read-during-write: single port, so a write in the read cycle is always
    // to the same address; write-first forwards the incoming word.
    always_comb begin
        rd_word = mem[addr];
        if (RDW_MODE != 0 && wr_en)
            rd_word = wr_word;
    end

    // Clear-engine FSM; an INIT_CLEAR build arms a clear that starts on the
    // first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            init_pend <= INIT_CLEAR;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_clr) begin
                        state     <= S_CLEAR;
                        ptr       <= '0;
                        init_pend <= 1'b0;
                    end
                end
                default: begin
                    ptr <= ptr + 1'b1;
                    if (&ptr)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array: clear engine owns the port while busy; contents are not reset.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            mem[ptr] <= clr_word;
        else if (wr_en)
            mem[addr] <= wr_word;
    end

    // Read data pipeline; entries already in flight finish even if a clear starts.
    always_ff @(posedge clk) begin
        if (rd_en)
            dat_pipe[0] <= rd_word;
        for (int i = 1; i < READ_LAT; i++)
            dat_pipe[i] <= dat_pipe[i-1];
    end

    // Read valid shift register, flushed by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_en;
            for (int i = 1; i < READ_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Output register: out only moves on a completing read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= vld_pipe[LAST];
            if (vld_pipe[LAST])
                out <= dat_pipe[LAST][DATA_W-1:0];
        end
    end

`ifdef RAM_PARITY_EN
    // Parity flag accompanies the out_valid pulse only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else
            err <= vld_pipe[LAST] &&
                   (dat_pipe[LAST][DATA_W] != ^dat_pipe[LAST][DATA_W-1:0]);
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_param.sv
// Directed bench for ram_param: four instances share one stimulus stream
// (default/read-first, write-first, two-cycle latency, small INIT_CLEAR).
module tb_ram_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  in = '0;
    logic [11:0] addr = '0;

    logic [3:0] out0, out1, out2, out3;
    logic       ov0, ov1, ov2, ov3;
    logic       bz0, bz1, bz2, bz3;
    logic       er0, er1, er2, er3;

    int ncmp = 0;
    int nfail = 0;
    int cnt;
    int ovc;

    always #5 clk = ~clk;

    ram_param #(.CLEAR_VAL(4'h5)) d0 (
        .clk(clk), .rst_n(rst_n), .write(write), .read(read), .in(in), .addr(addr),
        .clear(clear), .out(out0), .out_valid(ov0), .busy(bz0), .err(er0));
    ram_param #(.CLEAR_VAL(4'h5), .RDW_MODE(1)) d1 (
        .clk(clk), .rst_n(rst_n), .write(write), .read(read), .in(in), .addr(addr),
        .clear(clear), .out(out1), .out_valid(ov1), .busy(bz1), .err(er1));
    ram_param #(.CLEAR_VAL(4'h5), .READ_LAT(2)) d2 (
        .clk(clk), .rst_n(rst_n), .write(write), .read(read), .in(in), .addr(addr),
        .clear(clear), .out(out2), .out_valid(ov2), .busy(bz2), .err(er2));
    ram_param #(.ADDR_W(4), .INIT_CLEAR(1'b1)) d3 (
        .clk(clk), .rst_n(rst_n), .write(write), .read(read), .in(in), .addr(addr[3:0]),
        .clear(clear), .out(out3), .out_valid(ov3), .busy(bz3), .err(er3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [3:0] d);
        write = 1'b1; addr = a; in = d;
        tick();
        write = 1'b0;
    endtask

    // Single read on d0: issue, then one more edge for READ_LAT=1.
    task automatic rd0(input logic [11:0] a, input logic [3:0] exp, input string tag);
        read = 1'b1; addr = a;
        tick();
        read = 1'b0;
        tick();
        chk({tag, "_ov"}, 32'(ov0), 32'd1);
        chk(tag, 32'(out0), 32'(exp));
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_out", 32'(out0), 32'h0);
        chk("rst_ov", 32'(ov0), 32'h0);
        chk("rst_busy", 32'(bz0), 32'h0);
        chk("rst_err", 32'(er0), 32'h0);
        chk("rst_busy3", 32'(bz3), 32'h0);
        #11 rst_n = 1'b1;

        // INIT_CLEAR instance: busy from first edge, DEPTH=16 cycles
        tick();
        chk("init_busy_start", 32'(bz3), 32'h1);
        repeat (15) tick();
        chk("init_busy_last", 32'(bz3), 32'h1);
        tick();
        chk("init_busy_end", 32'(bz3), 32'h0);

        // 1: write then read, READ_LAT=1
        wr(12'd0, 4'b0011);
        read = 1'b1; addr = 12'd0;
        tick();
        read = 1'b0;
        chk("t1_ov_early", 32'(ov0), 32'h0);
        tick();
        chk("t1_ov", 32'(ov0), 32'h1);
        chk("t1_out", 32'(out0), 32'h3);
        chk("t1_ov2_early", 32'(ov2), 32'h0);
        tick();
        chk("t1_ov_drop", 32'(ov0), 32'h0);
        chk("t1_out_hold", 32'(out0), 32'h3);
        chk("t1_ov2", 32'(ov2), 32'h1);
        chk("t1_out2", 32'(out2), 32'h3);

        // 2: read-during-write ordering
        wr(12'd1, 4'h9);
        write = 1'b1; read = 1'b1; addr = 12'd1; in = 4'b0001;
        tick();
        write = 1'b0; read = 1'b0;
        tick();
        chk("t2_rf_out", 32'(out0), 32'h9);
        chk("t2_wf_out", 32'(out1), 32'h1);
        chk("t2_wf_ov", 32'(ov1), 32'h1);

        // 3: READ_LAT=2 back-to-back reads of 0,1,2
        wr(12'd2, 4'h6);
        read = 1'b1; addr = 12'd0;
        tick();
        addr = 12'd1;
        tick();
        chk("t3_ov_lag", 32'(ov2), 32'h0);
        addr = 12'd2;
        tick();
        read = 1'b0;
        chk("t3_ov_a", 32'(ov2), 32'h1);
        chk("t3_out_a", 32'(out2), 32'h3);
        tick();
        chk("t3_ov_b", 32'(ov2), 32'h1);
        chk("t3_out_b", 32'(out2), 32'h1);
        tick();
        chk("t3_ov_c", 32'(ov2), 32'h1);
        chk("t3_out_c", 32'(out2), 32'h6);
        tick();
        chk("t3_ov_end", 32'(ov2), 32'h0);
        chk("t3_out_hold", 32'(out2), 32'h6);

        // 4: fill, clear with colliding read/write, writes/reads/clear while busy
        for (int a = 0; a < 8; a++) wr(12'(a), 4'hA);
        wr(12'd4095, 4'h7);
        clear = 1'b1; read = 1'b1; write = 1'b1; addr = 12'd5; in = 4'hF;
        tick();
        clear = 1'b0; addr = 12'd0;
        chk("t4_busy_start", 32'(bz0), 32'h1);
        cnt = 0; ovc = 0;
        while (bz0 && cnt < 5000) begin
            cnt++;
            if (ov0) ovc++;
            clear = (cnt == 2000);
            tick();
        end
        clear = 1'b0; read = 1'b0; write = 1'b0;
        chk("t4_busy_cycles", 32'(cnt), 32'd4096);
        chk("t4_ov_while_busy", 32'(ovc), 32'd0);
        for (int a = 0; a < 8; a++) rd0(12'(a), 4'h5, "t4_rd");
        rd0(12'd4095, 4'h5, "t4_rd_top");

        // 5: reset in the middle of a clear, ptr=100
        wr(12'd99, 4'hC);
        wr(12'd100, 4'hC);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (100) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(bz0), 32'h0);
        chk("t5_out", 32'(out0), 32'h0);
        chk("t5_ov", 32'(ov0), 32'h0);
        #2 rst_n = 1'b1;
        tick();
        chk("t5_busy_after", 32'(bz0), 32'h0);
        rd0(12'd0, 4'h5, "t5_rd0");
        rd0(12'd99, 4'h5, "t5_rd99");
        rd0(12'd100, 4'hC, "t5_rd100");
        chk("t5_err_clean", 32'(er0), 32'h0);

`ifdef RAM_PARITY_EN
        // 6: corrupt a stored bit and check the parity flag
        wr(12'd3, 4'b0111);
        force d0.mem[3] = 5'b1_0110;
        read = 1'b1; addr = 12'd3;
        tick();
        read = 1'b0;
        release d0.mem[3];
        tick();
        chk("t6_ov", 32'(ov0), 32'h1);
        chk("t6_err", 32'(er0), 32'h1);
        tick();
        chk("t6_err_drop", 32'(er0), 32'h0);
        rd0(12'd0, 4'h5, "t6_rd0");
        chk("t6_err_clean", 32'(er0), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    // Safety net in case a wait above never resolves.
    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
